// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC register / instruction-fetch sequencer.
// Optional misaligned-redirect trap is enabled with PC_MISALIGN_TRAP_EN.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Next-PC select: live redirect beats a pending redirect, which beats PC_plus4.
// With PC_MISALIGN_TRAP_EN a misaligned target becomes TRAP_VEC; otherwise low bits are masked.
module next_pc_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        pend_vld,
  input  logic [31:0] pend_target,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        trap,
`endif
  output logic [31:0] next_pc
);

  logic        use_tgt;
  logic [31:0] raw_tgt;

  always_comb begin
    use_tgt = redirect | pend_vld;
    raw_tgt = redirect ? redirect_target : pend_target;
`ifdef PC_MISALIGN_TRAP_EN
    trap = use_tgt && (raw_tgt[1:0] != 2'b00);
    if (!use_tgt)  next_pc = pc_plus4;
    else if (trap) next_pc = TRAP_VEC;
    else           next_pc = raw_tgt;
`else
    next_pc = use_tgt ? (raw_tgt & ~32'h0000_0003) : pc_plus4;
`endif
  end

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus req/ready fetch sequencer (IDLE -> REQ <-> HOLD).
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] PC_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        misaligned
);

  fetch_state_e state;
  logic         pend_vld;
  logic [31:0]  pend_target;
  logic [31:0]  next_pc;
  logic         resp;
  logic         pc_upd;

  assign imem_addr = PC;

  // A response with a pending redirect is a discard, so it advances the PC even under stall.
  always_comb begin
    resp   = (state == REQ) && imem_ready;
    pc_upd = (resp && (pend_vld || !stall)) || ((state == HOLD) && !stall);
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap;
`endif

  next_pc_mux #(
    .TRAP_VEC(TRAP_VEC)
  ) u_next_pc_mux (
    .pc_plus4       (PC_plus4),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pend_vld       (pend_vld),
    .pend_target    (pend_target),
`ifdef PC_MISALIGN_TRAP_EN
    .trap           (trap),
`endif
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      pend_vld    <= 1'b0;
    end else begin
      if (pc_upd) PC <= next_pc;

      if (pc_upd)                          pend_vld <= 1'b0;
      else if (redirect && state != IDLE)  pend_vld <= 1'b1;

      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            instr_valid <= !pend_vld;
            if (!pend_vld) instr <= imem_rdata;
            if (!pend_vld && stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else begin
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Newest redirect always overwrites; the valid flag alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (redirect && !pc_upd) pend_target <= redirect_target;
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) misaligned <= 1'b0;
    else        misaligned <= pc_upd && trap;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then randomized traffic vs. a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        misaligned;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC(RPC),
    .TRAP_VEC(TVEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC             (PC),
    .PC_plus4       (PC_plus4),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .misaligned     (misaligned)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: "running" = fetching has begun, "hold" = delivered word parked under stall,
  // m_pend = at most one remembered redirect target (newest wins).
  bit          m_run, m_hold, m_valid, m_mis;
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_pend[$];

  function automatic logic [31:0] land(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      m_mis = 1'b1;
      return TVEC;
    end
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic step(input bit rn, input bit rdy, input bit stl, input bit rd, input logic [31:0] tgt);
    logic [31:0] dat;
    logic [31:0] plus4;
    dat             = $urandom;
    plus4           = m_pc + 32'd4;
    rst_n           = rn;
    imem_ready      = rdy;
    stall           = stl;
    redirect        = rd;
    redirect_target = tgt;
    imem_rdata      = dat;
    PC_plus4        = plus4;
    @(posedge clk);
    if (!rn) begin
      m_pc = RPC; m_run = 0; m_hold = 0; m_valid = 0; m_instr = NOP; m_mis = 0;
      m_pend.delete();
    end else begin
      m_mis = 0;
      if (!m_run) begin
        m_run = 1;
      end else if (m_hold) begin
        if (rd) begin m_pend.delete(); m_pend.push_back(tgt); end
        if (!stl) begin
          m_pc = (m_pend.size() > 0) ? land(m_pend[0]) : plus4;
          m_pend.delete();
          m_hold = 0;
          m_valid = 0;
        end
      end else if (rdy) begin
        if (m_pend.size() > 0) begin
          m_valid = 0;
          m_pc = land(rd ? tgt : m_pend[0]);
          m_pend.delete();
        end else begin
          m_instr = dat;
          m_valid = 1;
          if (stl) begin
            m_hold = 1;
            if (rd) m_pend.push_back(tgt);
          end else begin
            m_pc = rd ? land(tgt) : plus4;
          end
        end
      end else begin
        m_valid = 0;
        if (rd) begin m_pend.delete(); m_pend.push_back(tgt); end
      end
    end
    #1;
    check_eq("pc", PC, m_pc);
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_run && !m_hold});
    if (m_run && !m_hold) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check_eq("instr", instr, m_instr);
    check_eq("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  initial begin
    m_pc = RPC; m_instr = NOP;

    // Reset, with a late ready that must be ignored
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_instr", instr, 32'h13);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait streaming
    step(1, 1, 0, 0, 0);
    check_eq("first_addr", imem_addr, 32'h0);
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    step(1, 1, 0, 0, 0);
    check_eq("stream_addr4", imem_addr, 32'h4);
    check_eq("stream_vld", {31'd0, instr_valid}, 32'd1);
    step(1, 1, 0, 0, 0);
    check_eq("stream_addr8", imem_addr, 32'h8);

    // Three wait cycles at 0x8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      check_eq("wait_addr", imem_addr, 32'h8);
      check_eq("wait_vld", {31'd0, instr_valid}, 32'd0);
    end
    step(1, 1, 0, 0, 0);
    check_eq("wait_done_pc", PC, 32'hC);
    step(1, 1, 0, 0, 0);

    // Redirect during a wait at 0x10: response discarded
    step(1, 0, 0, 1, 32'h40);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_eq("redir_pc", PC, 32'h40);
    check_eq("redir_discard", {31'd0, instr_valid}, 32'd0);

    // Stall on a response at 0x40 for two cycles
    step(1, 1, 1, 0, 0);
    check_eq("stall_pc", PC, 32'h40);
    check_eq("stall_vld", {31'd0, instr_valid}, 32'd1);
    step(1, 0, 1, 0, 0);
    check_eq("hold_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 0, 0, 0);
    check_eq("unstall_pc", PC, 32'h44);

    // Misaligned redirect alongside a response
    step(1, 1, 0, 1, 32'h42);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("mis_pc", PC, 32'h100);
    check_eq("mis_pulse", {31'd0, misaligned}, 32'd1);
`else
    check_eq("mask_pc", PC, 32'h40);
    check_eq("mask_pulse", {31'd0, misaligned}, 32'd0);
`endif

    // Reset while holding
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("hold_rst_pc", PC, 32'h0);
    check_eq("hold_rst_vld", {31'd0, instr_valid}, 32'd0);
    check_eq("hold_rst_instr", instr, 32'h13);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rn, rdy, stl, rd;
      logic [31:0] tgt;
      rn  = ($urandom_range(0, 59) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom & 32'hFFFF_FFFC;
        1:       tgt = $urandom;
        2:       tgt = 32'hFFFF_FFFC;
        default: tgt = {24'd0, $urandom_range(0, 255)} & 32'hFF;
      endcase
      step(rn, rdy, stl, rd, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
